ofdm_tx_cp_framer: RTL and testbench
====================================

# ofdm_tx_cp_framer

Transmit-side symbol framer for the OFDM link, the counterpart of the RX path that strips the cyclic prefix. It accepts 128-sample raw time-domain symbols (IFFT output, I/Q) through a ready/valid interface and buffers them in a ping-pong RAM. Each symbol is emitted as 160 samples: a 32-sample cyclic prefix followed by the 128-sample body. Output samples are paced at one strobe every `osr_c` clocks, matching the sample rate the RX path expects on `rx_data_valid`.

## Interface
- `sample_bit_width_c`, 12, signed width of I and Q samples
- `symbol_length_c`, 160, output samples per symbol including CP
- `raw_symbol_length_c`, 128, input samples per symbol; CP length = `symbol_length_c - raw_symbol_length_c` (32)
- `osr_c`, 10, clocks per output sample strobe
- `sys_clk`  in  1  system clock; all logic on rising edge
- `sys_rstn`  in  1  reset, synchronous, active-low
- `sys_init`  in  1  synchronous soft clear, same effect as reset
- `in_data_i`, `in_data_q`  in  `sample_bit_width_c`  raw symbol sample, signed
- `in_data_valid`  in  1  input sample valid
- `in_data_start`  in  1  qualifies the first sample (index 0) of a symbol
- `in_ready`  out  1  framer can accept a sample this cycle
- `tx_data_i`, `tx_data_q`  out  `sample_bit_width_c`  framed output sample
- `tx_data_valid`  out  1  one-cycle strobe per output sample
- `tx_data_start`  out  1  high with the first CP sample of each symbol

## Operation
- Storage: two banks of `raw_symbol_length_c` I/Q words, with flags `full[1:0]`, write pointer `wr_bank`/`wr_idx`, and read pointer `rd_bank`.
- Accept: a sample is accepted when `in_data_valid && in_ready`. `in_ready = !full[wr_bank]`.
- Write FSM, states `W_IDLE` and `W_FILL`:
  - `W_IDLE`: an accepted sample without `in_data_start` is dropped. An accepted sample with `in_data_start` is written to index 0, sets `wr_idx=1`, and moves to `W_FILL`.
  - `W_FILL`: an accepted sample with `in_data_start` restarts the symbol: the partial symbol is discarded, the sample goes to index 0, and `wr_idx=1`. Otherwise the sample is written to `wr_idx` and `wr_idx` increments.
  - Writing index 127 sets `full[wr_bank]`, toggles `wr_bank`, and returns to `W_IDLE`.
- Pacing: `tick_cnt` runs free 0..`osr_c-1` from reset. A tick occurs when `tick_cnt == osr_c-1`.
- Read FSM, states `R_IDLE` and `R_SEND`, with `out_cnt` 0..159:
  - `R_IDLE`, on a tick with `full[rd_bank]`: emit `out_cnt=0`, assert `tx_data_start`, go to `R_SEND`.
  - `R_SEND`, on each tick: increment `out_cnt` and emit that sample.
  - Sample index emitted: `out_cnt + 96` for `out_cnt` < 32 (indices 96..127), else `out_cnt - 32` (indices 0..127).
  - After emitting `out_cnt=159`: clear `full[rd_bank]`, toggle `rd_bank`, go to `R_IDLE`.
  - The next tick can start the next symbol, so back-to-back symbols have no gap.
- No full bank at a symbol boundary: no strobes are issued. `tx_data_i/q` hold their last value.
- Simultaneous release and write-complete: these hit different banks. Both flag updates take effect. `in_ready` recovers the cycle after the release.
- `sys_init` or reset, including mid-symbol: clears all flags, pointers, counters and FSMs. Both buffered symbols are lost.

## Timing
- Reset values: `tx_data_i = tx_data_q = 0`, `tx_data_valid = 0`, `tx_data_start = 0`, `in_ready = 1`, `tick_cnt = 0`.
- All outputs are registered. `tx_data_*` update on the clock edge that ends the tick cycle and are valid for the cycle after the tick. `tx_data_valid` and `tx_data_start` are high for exactly that one cycle.
- Output strobes within a symbol are exactly `osr_c` clocks apart. A full symbol spans 160·`osr_c` clocks.
- Input to output latency: the first CP strobe follows the first tick after the 128th sample is written, i.e. 1 to `osr_c` clocks later plus 1 register stage.
- `in_ready` is combinational from registered `full` flags. It drops the cycle after the second bank fills.
- Input may arrive at up to one sample per clock.

## Test plan
- Reset hold, then release: all outputs 0, `in_ready = 1`, no `tx_data_valid` for 2000 clocks with no input.
- One symbol, ramp I=k, Q=−k for k=0..127 at full rate → 160 strobes spaced 10 clocks apart, I sequence 96..127 then 0..127, `tx_data_start` on the first strobe only.
- Two symbols back-to-back → strobe 161 is the second symbol's index 96, exactly 10 clocks after strobe 160, with `tx_data_start` high.
- Three symbols at full rate → `in_ready` low after 256 samples accepted, high again the cycle after the first symbol's 160th strobe; the third symbol's data is intact.
- 50 samples, then `in_data_start` with a new ramp of 128 samples → output body is the new ramp only; no strobe occurs before the new symbol completes.
- `sys_init` pulsed at strobe 80 → no further strobes, `in_ready = 1`; next full symbol framed correctly from index 96.

Source files
------------

// File: rtl/ofdm_tx_cp_framer.sv
// Purpose: TX OFDM framer; buffers 128-sample IFFT symbols in a ping-pong RAM, emits 32-sample CP + 128-sample body.
// Latency: first CP strobe 1..osr_c clocks after the last input sample is written, then one strobe every osr_c clocks.
// Backpressure: in_ready = !full[wr_bank]; input stalls only when both banks hold unsent symbols.
//
// Ports:
//   sys_clk, sys_rstn (sync, active-low), sys_init (sync soft clear, same effect as reset)
//   in_data_i/q, in_data_valid, in_data_start, in_ready  : raw symbol input, ready/valid
//   tx_data_i/q, tx_data_valid, tx_data_start            : paced framed output, registered
module ofdm_tx_cp_framer #(
    parameter int sample_bit_width_c  = 12,
    parameter int symbol_length_c     = 160,
    parameter int raw_symbol_length_c = 128,
    parameter int osr_c               = 10
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rstn,
    input  logic                                 sys_init,
    input  logic signed [sample_bit_width_c-1:0] in_data_i,
    input  logic signed [sample_bit_width_c-1:0] in_data_q,
    input  logic                                 in_data_valid,
    input  logic                                 in_data_start,
    output logic                                 in_ready,
    output logic signed [sample_bit_width_c-1:0] tx_data_i,
    output logic signed [sample_bit_width_c-1:0] tx_data_q,
    output logic                                 tx_data_valid,
    output logic                                 tx_data_start
);

    localparam int CP_LEN = symbol_length_c - raw_symbol_length_c;
    localparam int IDX_W  = $clog2(raw_symbol_length_c);
    localparam int CNT_W  = $clog2(symbol_length_c);
    localparam int TICK_W = (osr_c > 1) ? $clog2(osr_c) : 1;

    typedef struct packed {
        logic signed [sample_bit_width_c-1:0] i;
        logic signed [sample_bit_width_c-1:0] q;
    } iq_t;

    typedef enum logic { W_IDLE, W_FILL } wr_state_t;
    typedef enum logic { R_IDLE, R_SEND } rd_state_t;

    // Bank select is the address MSB: {bank, index}.
    iq_t mem [0:2*raw_symbol_length_c-1];

    wr_state_t        wr_state, wr_state_nxt;
    rd_state_t        rd_state, rd_state_nxt;
    logic [1:0]       full, full_set, full_clr;
    logic             wr_bank, wr_bank_nxt;
    logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
    logic             rd_bank, rd_bank_nxt;
    logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
    logic [TICK_W-1:0] tick_cnt;

    logic             clr;
    logic             accept;
    logic             tick;
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic             emit;
    logic             emit_start;
    logic [CNT_W-1:0] emit_cnt;
    logic [IDX_W-1:0] rd_idx;

    assign clr      = !sys_rstn || sys_init;
    assign in_ready = !full[wr_bank];
    assign accept   = in_data_valid && in_ready;
    assign tick     = (tick_cnt == TICK_W'(osr_c - 1));

    // Write side: only a start-qualified sample opens a symbol; a new start
    // mid-fill throws away the partial symbol and restarts at index 0.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_idx_nxt   = wr_idx;
        wr_bank_nxt  = wr_bank;
        mem_we       = 1'b0;
        mem_widx     = '0;
        full_set     = 2'b00;
        case (wr_state)
            W_IDLE: begin
                if (accept && in_data_start) begin
                    mem_we       = 1'b1;
                    mem_widx     = '0;
                    wr_idx_nxt   = IDX_W'(1);
                    wr_state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (accept) begin
                    mem_we = 1'b1;
                    if (in_data_start) begin
                        mem_widx   = '0;
                        wr_idx_nxt = IDX_W'(1);
                    end else begin
                        mem_widx = wr_idx;
                        if (wr_idx == IDX_W'(raw_symbol_length_c - 1)) begin
                            full_set[wr_bank] = 1'b1;
                            wr_bank_nxt       = !wr_bank;
                            wr_idx_nxt        = '0;
                            wr_state_nxt      = W_IDLE;
                        end else begin
                            wr_idx_nxt = wr_idx + IDX_W'(1);
                        end
                    end
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Read side: emit_cnt is the output position loaded on this tick.
    always_comb begin
        rd_state_nxt = rd_state;
        out_cnt_nxt  = out_cnt;
        rd_bank_nxt  = rd_bank;
        full_clr     = 2'b00;
        emit         = 1'b0;
        emit_start   = 1'b0;
        emit_cnt     = '0;
        case (rd_state)
            R_IDLE: begin
                if (tick && full[rd_bank]) begin
                    emit         = 1'b1;
                    emit_start   = 1'b1;
                    emit_cnt     = '0;
                    out_cnt_nxt  = '0;
                    rd_state_nxt = R_SEND;
                end
            end
            R_SEND: begin
                if (tick) begin
                    emit        = 1'b1;
                    emit_cnt    = out_cnt + CNT_W'(1);
                    out_cnt_nxt = emit_cnt;
                    // Release on the last sample so the next tick can start
                    // the other bank with no gap.
                    if (emit_cnt == CNT_W'(symbol_length_c - 1)) begin
                        full_clr[rd_bank] = 1'b1;
                        rd_bank_nxt       = !rd_bank;
                        out_cnt_nxt       = '0;
                        rd_state_nxt      = R_IDLE;
                    end
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // CP positions map to the tail of the body, the rest to the body in order.
    always_comb begin
        if (emit_cnt < CNT_W'(CP_LEN)) begin
            rd_idx = IDX_W'(emit_cnt) + IDX_W'(raw_symbol_length_c - CP_LEN);
        end else begin
            rd_idx = IDX_W'(emit_cnt - CNT_W'(CP_LEN));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (mem_we && !clr) begin
            mem[{wr_bank, mem_widx}] <= iq_t'({in_data_i, in_data_q});
        end
    end

    always_ff @(posedge sys_clk) begin
        if (clr) begin
            wr_state      <= W_IDLE;
            rd_state      <= R_IDLE;
            full          <= 2'b00;
            wr_bank       <= 1'b0;
            wr_idx        <= '0;
            rd_bank       <= 1'b0;
            out_cnt       <= '0;
            tick_cnt      <= '0;
            tx_data_i     <= '0;
            tx_data_q     <= '0;
            tx_data_valid <= 1'b0;
            tx_data_start <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            // Set and clear always target different banks, so both apply.
            full     <= (full & ~full_clr) | full_set;
            wr_bank  <= wr_bank_nxt;
            wr_idx   <= wr_idx_nxt;
            rd_bank  <= rd_bank_nxt;
            out_cnt  <= out_cnt_nxt;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            if (emit) begin
                tx_data_i <= mem[{rd_bank, rd_idx}].i;
                tx_data_q <= mem[{rd_bank, rd_idx}].q;
            end
            tx_data_valid <= emit;
            tx_data_start <= emit_start;
        end
    end

endmodule

// File: tb/tb_ofdm_tx_cp_framer.sv
module tb_ofdm_tx_cp_framer;

    localparam int W   = 12;
    localparam int SYM = 160;
    localparam int RAW = 128;
    localparam int OSR = 10;
    localparam int CP  = SYM - RAW;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                init = 1'b0;
    logic signed [W-1:0] in_i = '0;
    logic signed [W-1:0] in_q = '0;
    logic                in_vld = 1'b0;
    logic                in_start = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] tx_i;
    logic signed [W-1:0] tx_q;
    logic                tx_vld;
    logic                tx_start;

    ofdm_tx_cp_framer #(
        .sample_bit_width_c (W),
        .symbol_length_c    (SYM),
        .raw_symbol_length_c(RAW),
        .osr_c              (OSR)
    ) dut (
        .sys_clk      (clk),
        .sys_rstn     (rstn),
        .sys_init     (init),
        .in_data_i    (in_i),
        .in_data_q    (in_q),
        .in_data_valid(in_vld),
        .in_data_start(in_start),
        .in_ready     (in_ready),
        .tx_data_i    (tx_i),
        .tx_data_q    (tx_q),
        .tx_data_valid(tx_vld),
        .tx_data_start(tx_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cap_i[$];
    int cap_q[$];
    int cap_c[$];
    bit cap_s[$];

    always @(negedge clk) begin
        if (tx_vld) begin
            cap_i.push_back(int'(tx_i));
            cap_q.push_back(int'(tx_q));
            cap_s.push_back(tx_start);
            cap_c.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int last_acc_cyc = 0;

    typedef struct {
        int strobe;
        int exp_i;
        int exp_q;
        bit exp_st;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic clear_caps();
        cap_i.delete();
        cap_q.delete();
        cap_s.delete();
        cap_c.delete();
    endtask

    // Called #1 after a posedge; the sample is taken at the first edge with in_ready.
    task automatic push(input int val, input bit st);
        int nv;
        int guard;
        nv = -val;
        in_i     = val[W-1:0];
        in_q     = nv[W-1:0];
        in_start = st;
        in_vld   = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 6000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 6000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: in_ready stayed %0d, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_vld       = 1'b0;
        in_start     = 1'b0;
        last_acc_cyc = cyc;
    endtask

    task automatic send_sym(input int base, input int n);
        for (int k = 0; k < n; k++) push(base + k, k == 0);
    endtask

    task automatic wait_strobes(input int n, input int budget, input string nm);
        int guard;
        guard = 0;
        while (cap_i.size() < n && guard < budget) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (cap_i.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d strobes, required %0d", nm, cap_i.size(), n);
        end
    endtask

    task automatic do_init();
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        clear_caps();
    endtask

    // Reference framing: CP position k<32 carries body index k+96, else k-32.
    task automatic check_symbol(input int first, input int base, input string nm);
        int errs;
        int idx;
        int bad_k;
        int bad_got;
        int bad_exp;
        errs = 0;
        bad_k = -1;
        bad_got = 0;
        bad_exp = 0;
        n_cmp++;
        if (cap_i.size() < first + SYM) begin
            errs = 1;
            bad_got = cap_i.size();
            bad_exp = first + SYM;
        end else begin
            for (int k = 0; k < SYM; k++) begin
                idx = (k < CP) ? k + (RAW - CP) : k - CP;
                if (cap_i[first+k] != base + idx || cap_q[first+k] != -(base + idx) ||
                    cap_s[first+k] != (k == 0)) begin
                    if (errs == 0) begin
                        bad_k = k;
                        bad_got = cap_i[first+k];
                        bad_exp = base + idx;
                    end
                    errs++;
                end
            end
        end
        if (errs != 0) begin
            n_bad++;
            $display("FAIL %s: %0d bad strobes, first at %0d got I=%0d, required I=%0d",
                     nm, errs, bad_k, bad_got, bad_exp);
        end
    endtask

    task automatic check_spacing(input int from, input int to, input string nm);
        int errs;
        errs = 0;
        for (int k = from + 1; k <= to; k++) begin
            if (k >= cap_c.size() || cap_c[k] - cap_c[k-1] != OSR) errs++;
        end
        check(nm, errs, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int nst;
        vt[0] = '{0,   96,  -96,  1'b1};
        vt[1] = '{1,   97,  -97,  1'b0};
        vt[2] = '{31,  127, -127, 1'b0};
        vt[3] = '{32,  0,   0,    1'b0};
        vt[4] = '{33,  1,   -1,   1'b0};
        vt[5] = '{95,  63,  -63,  1'b0};
        vt[6] = '{159, 127, -127, 1'b0};

        // Reset hold and idle
        rstn = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_tx_i", int'(tx_i), 0);
        check("rst_tx_q", int'(tx_q), 0);
        check("rst_tx_valid", tx_vld, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2000) @(posedge clk);
        #1;
        check("idle_no_strobes", cap_i.size(), 0);

        // One symbol, ramp
        send_sym(0, RAW);
        wait_strobes(SYM, 3000, "sym1_wait");
        for (int v = 0; v < 7; v++) begin
            n_cmp++;
            if (vt[v].strobe >= cap_i.size() ||
                cap_i[vt[v].strobe] != vt[v].exp_i || cap_q[vt[v].strobe] != vt[v].exp_q ||
                cap_s[vt[v].strobe] != vt[v].exp_st) begin
                n_bad++;
                if (vt[v].strobe < cap_i.size())
                    $display("FAIL table[%0d] strobe %0d: got I=%0d Q=%0d st=%0d, required I=%0d Q=%0d st=%0d",
                             v, vt[v].strobe, cap_i[vt[v].strobe], cap_q[vt[v].strobe],
                             cap_s[vt[v].strobe], vt[v].exp_i, vt[v].exp_q, vt[v].exp_st);
                else
                    $display("FAIL table[%0d]: got %0d strobes, required > %0d",
                             v, cap_i.size(), vt[v].strobe);
            end
        end
        check_spacing(0, SYM - 1, "sym1_spacing");
        nst = 0;
        foreach (cap_s[k]) nst += int'(cap_s[k]);
        check("sym1_start_count", nst, 1);
        d = (cap_c.size() > 0) ? cap_c[0] - last_acc_cyc : -1;
        n_cmp++;
        if (d < 1 || d > OSR) begin
            n_bad++;
            $display("FAIL sym1_latency: got %0d clocks, required 1..%0d", d, OSR);
        end
        repeat (30) @(posedge clk);
        #1;
        check("sym1_no_extra", cap_i.size(), SYM);

        // Two symbols back-to-back
        do_init();
        send_sym(0, RAW);
        send_sym(300, RAW);
        wait_strobes(2 * SYM, 5000, "b2b_wait");
        check("b2b_s161_i", (cap_i.size() > SYM) ? cap_i[SYM] : -1, 300 + 96);
        check("b2b_s161_start", (cap_s.size() > SYM) ? int'(cap_s[SYM]) : -1, 1);
        check("b2b_gap", (cap_c.size() > SYM) ? cap_c[SYM] - cap_c[SYM-1] : -1, OSR);
        check_symbol(SYM, 300, "b2b_sym2");

        // Three symbols at full rate, backpressure
        do_init();
        send_sym(0, RAW);
        send_sym(500, RAW);
        check("ready_low_256", in_ready, 0);
        fork
            send_sym(1000, RAW);
            begin
                wait_strobes(SYM - 1, 3000, "bp_wait159");
                check("ready_low_s159", in_ready, 0);
                wait_strobes(SYM, 100, "bp_wait160");
                @(negedge clk);
                #1;
                check("ready_high_after_s160", in_ready, 1);
            end
        join
        wait_strobes(3 * SYM, 6000, "bp_wait480");
        check_symbol(0, 0, "bp_sym1");
        check_symbol(2 * SYM, 1000, "bp_sym3_intact");

        // Drop without start, partial restart
        do_init();
        for (int k = 0; k < 5; k++) push(1500 + k, 1'b0);
        send_sym(700, 50);
        send_sym(1200, RAW);
        check("restart_no_early", cap_i.size(), 0);
        wait_strobes(SYM, 3000, "restart_wait");
        check_symbol(0, 1200, "restart_body");
        repeat (50) @(posedge clk);
        #1;
        check("restart_no_extra", cap_i.size(), SYM);

        // Soft clear mid-symbol
        do_init();
        send_sym(100, RAW);
        wait_strobes(80, 2000, "init_wait80");
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        check("init_in_ready", in_ready, 1);
        check("init_tx_valid", tx_vld, 0);
        check("init_tx_i", int'(tx_i), 0);
        repeat (2000) @(posedge clk);
        #1;
        check("init_no_strobes", cap_i.size(), 80);
        clear_caps();
        send_sym(1700, RAW);
        wait_strobes(SYM, 3000, "post_init_wait");
        check_symbol(0, 1700, "post_init_sym");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
